pcm_stereo_feeder: RTL

//  Upstream sample source for the PT8211 DAC serializer. Buffers stereo PCM frames {L,R} in a

---
 rtl/pcm_stereo_feeder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pcm_stereo_feeder.sv
// pcm_stereo_feeder
// Stereo PCM frame FIFO that feeds the PT8211 DAC serializer in the 1.536 MHz
// bit-clock domain. Each one-cycle serializer request is answered with the next
// 16-bit sample, interleaved L,R,L,R. A LEFT request on an empty FIFO is an
// underrun and plays silence. Dropped writes and underruns are counted with
// saturating counters.
//
// Build option: define PCM_FEEDER_VOLUME_EN to add the vol_shift[3:0] input.
// Each outgoing sample is then arithmetically shifted right by vol_shift.
// Without the macro, samples pass through unscaled.
module pcm_stereo_feeder #(
  parameter int FIFO_AW = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_1p536m,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  output logic             full,
  output logic [FIFO_AW:0] level,
  input  logic             mute,
  input  logic             req,
`ifdef PCM_FEEDER_VOLUME_EN
  input  logic [3:0]       vol_shift,
`endif
  output logic [15:0]      idata,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic [CNT_W-1:0] overflow_cnt
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW+1)'(1);
  localparam logic             CH_LEFT  = 1'b0;
  localparam logic             CH_RIGHT = 1'b1;

  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr;
  logic [FIFO_AW:0]   rd_ptr;
  logic               ch;
  logic signed [15:0] r_hold;
  logic               empty;
  logic               do_wr;
  logic               serve_left;
  logic               do_pop;
  logic [31:0]        rd_frame;
  logic signed [15:0] left_smp;
  logic signed [15:0] right_smp;
  logic [3:0]         vol;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Attenuation by arithmetic right shift; the sign is preserved.
  function automatic logic signed [15:0] scale(input logic signed [15:0] s,
                                               input logic [3:0] sh);
    return s >>> sh;
  endfunction

`ifdef PCM_FEEDER_VOLUME_EN
  assign vol = vol_shift;
`else
  assign vol = 4'd0;
`endif

  // Pointers are one bit wider than the address, so full and empty can be told apart.
  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == DEPTH_L);
  assign empty      = (level == '0);
  // The full flag is from before any pop in this cycle, so a same-cycle pop never frees room.
  assign do_wr      = wr_en && !full;
  assign serve_left = req && (ch == CH_LEFT);
  // The empty flag is from before any write in this cycle, so a same-cycle write is not visible.
  assign do_pop     = serve_left && !empty;
  assign rd_frame   = mem[rd_ptr[FIFO_AW-1:0]];
  assign left_smp   = signed'(rd_frame[31:16]);
  assign right_smp  = signed'(rd_frame[15:0]);

  // Frame storage holds data only, so it needs no reset.
  always_ff @(posedge clk_1p536m) begin
    if (do_wr) mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
  end

  // Advance the write and read pointers independently; a simultaneous push and pop leaves level unchanged.
  always_ff @(posedge clk_1p536m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Channel toggle and sample presentation; idata changes only on a request edge.
  always_ff @(posedge clk_1p536m or negedge rst_n) begin
    if (!rst_n) begin
      ch     <= CH_LEFT;
      idata  <= '0;
      r_hold <= '0;
    end else if (req) begin
      if (ch == CH_LEFT) begin
        ch <= CH_RIGHT;
        if (!empty) begin
          idata  <= mute ? 16'd0 : scale(left_smp, vol);
          r_hold <= right_smp;
        end else begin
          idata  <= '0;
          r_hold <= '0;
        end
      end else begin
        ch    <= CH_LEFT;
        idata <= mute ? 16'd0 : scale(r_hold, vol);
      end
    end
  end

  // Underrun and overflow event counters.
  always_ff @(posedge clk_1p536m or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
      overflow_cnt <= '0;
    end else begin
      if (serve_left && empty) underrun_cnt <= sat_inc(underrun_cnt);
      if (wr_en && full)       overflow_cnt <= sat_inc(overflow_cnt);
    end
  end

endmodule
